// File: rtl/acq_ctrl_pkg.sv
// Shared definitions for the acquisition control bank:
// register map, CTRL bit positions and run-state encoding.
package acq_ctrl_pkg;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h01;
  localparam logic [5:0] ADDR_DIV    = 6'h02;
  localparam logic [5:0] ADDR_TARGET = 6'h03;
  localparam logic [5:0] ADDR_COUNT  = 6'h04;
  localparam logic [5:0] ADDR_IRQ    = 6'h05;
  localparam logic [5:0] ADDR_MASK   = 6'h06;
  localparam logic [5:0] ADDR_PARAM  = 6'h08;
  localparam logic [5:0] ADDR_CH     = 6'h20;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_SRST  = 2;

  localparam int IRQ_DONE = 0;
  localparam int IRQ_HALF = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } acq_state_t;

endpackage

// File: rtl/acq_result_fifo.sv
// Synchronous result FIFO, DATA_W x DEPTH, show-ahead head word.
// Ports: push/din in, pop out via head, flush clears; accepted,
// full, empty and level (0..DEPTH) report occupancy.
module acq_result_fifo #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 256,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              accepted,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp, rp;
  logic [LW-1:0]     cnt;
  logic              rd_ok;

  assign full  = (cnt == LW'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;
  assign head  = mem[rp];
  assign rd_ok = pop && !empty;
  // A pop frees the slot being written, so a full FIFO
  // still takes the push when both happen together.
  assign accepted = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (accepted) wp <= wp + 1'b1;
      if (rd_ok)    rp <= rp + 1'b1;
      if (accepted && !rd_ok)
        cnt <= cnt + 1'b1;
      else if (!accepted && rd_ok)
        cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accepted) mem[wp] <= din;
  end

endmodule

// File: rtl/acq_control_bank.sv
// Acquisition controller: Avalon-MM register bank, run FSM,
// divisor/parameter registers and NUM_CH result FIFOs.
// Ports: avs_* slave (read latency 1), enable/soft_reset_out/
// divisor/param_out to fabric, calc_done + result_* from fabric.
// Build option ACQ_IRQ_EN: IRQ/mask registers and irq output;
// when undefined irq is 0 and 0x05/0x06 read as 0.
module acq_control_bank
  import acq_ctrl_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 256,
  parameter int NUM_PARAMS = 16,
  parameter int SRST_CYC   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [5:0]               avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata,
  output logic [31:0]              avs_readdata,
  output logic                     enable,
  output logic                     soft_reset_out,
  input  logic                     calc_done,
  output logic [31:0]              divisor,
  output logic [NUM_PARAMS*32-1:0] param_out,
  input  logic [NUM_CH*DATA_W-1:0] result_data,
  input  logic [NUM_CH-1:0]        result_valid,
  output logic                     irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(SRST_CYC + 1);

  acq_state_t state, state_nxt;

  logic [31:0]                 count, count_nxt, target;
  logic [31:0]                 params [NUM_PARAMS];
  logic [NUM_CH-1:0]           ovf, full, empty;
  logic [NUM_CH-1:0]           push, pop, accepted;
  logic [NUM_CH-1:0][LW-1:0]   level;
  logic [NUM_CH-1:0][31:0]     ch_rd;
  logic [SW-1:0]               srst_cnt;
  logic [31:0]                 rd_word, status;
  logic [31:0]                 irq_rd, mask_rd;
  logic                        wr_ctrl, do_start;
  logic                        do_stop, do_srst;
  logic                        capture, hit;

  assign wr_ctrl  = avs_write && (avs_address == ADDR_CTRL);
  assign do_srst  = wr_ctrl && avs_writedata[CTRL_SRST];
  assign do_stop  = wr_ctrl && avs_writedata[CTRL_STOP];
  assign do_start = wr_ctrl && avs_writedata[CTRL_START]
                    && !avs_writedata[CTRL_STOP];
  assign capture  = (state == RUN);

  always_comb begin
    count_nxt = count + {31'd0, accepted[0]};
    if (do_srst || do_start) count_nxt = '0;
  end

  // Terminate on the same edge that stores the target-th
  // sample so no further sample slips in behind it.
  assign hit = (target != '0) && (count_nxt == target);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (do_start) state_nxt = RUN;
      RUN:     if (do_stop || calc_done || hit)
                 state_nxt = DONE;
      DONE:    if (do_start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (do_srst) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      enable   <= 1'b0;
      count    <= '0;
      target   <= '0;
      divisor  <= 32'd1;
      ovf      <= '0;
      srst_cnt <= '0;
    end else begin
      state  <= state_nxt;
      enable <= (state_nxt == RUN);
      count  <= count_nxt;
      if (do_srst || do_start)
        ovf <= '0;
      else
        ovf <= ovf | (push & full & ~pop);
      if (do_srst)
        srst_cnt <= SW'(SRST_CYC);
      else if (srst_cnt != '0)
        srst_cnt <= srst_cnt - 1'b1;
      if (avs_write && avs_address == ADDR_DIV)
        divisor <= (avs_writedata == '0) ? 32'd1
                                         : avs_writedata;
      if (avs_write && avs_address == ADDR_TARGET)
        target <= avs_writedata;
    end
  end

  assign soft_reset_out = (srst_cnt != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_PARAMS; k++)
        params[k] <= '0;
    end else if (avs_write) begin
      for (int k = 0; k < NUM_PARAMS; k++)
        if (avs_address == ADDR_PARAM + 6'(k))
          params[k] <= avs_writedata;
    end
  end

  for (genvar k = 0; k < NUM_PARAMS; k++) begin : g_param
    assign param_out[32*k +: 32] = params[k];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic              sel, sel_lo;
    logic [DATA_W-1:0] head;
    logic [31:0]       hi_word, shadow;

    assign sel    = avs_address[5]
                    && (avs_address[4:2] == 3'(c));
    assign sel_lo = sel && (avs_address[1:0] == 2'd0);
    assign push[c] = capture && result_valid[c];
    assign pop[c]  = avs_read && sel_lo && !empty[c];

    acq_result_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (do_srst),
      .push     (push[c]),
      .din      (result_data[DATA_W*c +: DATA_W]),
      .pop      (pop[c]),
      .head     (head),
      .accepted (accepted[c]),
      .full     (full[c]),
      .empty    (empty[c]),
      .level    (level[c])
    );

    if (DATA_W > 32) begin : g_hi
      assign hi_word = head[63:32];
    end else begin : g_nohi
      assign hi_word = '0;
    end

    // HI shadow freezes the upper half of the word just
    // popped so a LO/HI pair reads as one 64-bit sample.
    always_ff @(posedge clk) begin
      if (!reset_n || do_srst)
        shadow <= '0;
      else if (avs_read && sel_lo)
        shadow <= empty[c] ? '0 : hi_word;
    end

    assign ch_rd[c] =
      !sel                        ? 32'd0 :
      (avs_address[1:0] == 2'd0)  ? (empty[c] ? 32'd0
                                              : head[31:0]) :
      (avs_address[1:0] == 2'd1)  ? shadow :
      (avs_address[1:0] == 2'd2)  ? 32'(level[c]) :
                                    32'd0;
  end

  assign status = {8'd0, 8'(empty), 8'(ovf),
                   5'd0, |ovf, state};

`ifdef ACQ_IRQ_EN
  logic [1:0] irq_flags, irq_mask, irq_clr;
  logic       half, enter_done;

  always_comb begin
    half = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (level[c] >= LW'(FIFO_DEPTH / 2)) half = 1'b1;
  end

  assign enter_done = (state != DONE) && (state_nxt == DONE);
  assign irq_clr = (avs_write && avs_address == ADDR_IRQ)
                   ? avs_writedata[1:0] : 2'b00;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_flags <= '0;
      irq_mask  <= '0;
    end else begin
      irq_flags[IRQ_DONE] <= (irq_flags[IRQ_DONE]
                              & ~irq_clr[IRQ_DONE])
                             | enter_done;
      irq_flags[IRQ_HALF] <= (irq_flags[IRQ_HALF]
                              & ~irq_clr[IRQ_HALF])
                             | half;
      if (avs_write && avs_address == ADDR_MASK)
        irq_mask <= avs_writedata[1:0];
    end
  end

  assign irq     = |(irq_flags & irq_mask);
  assign irq_rd  = {30'd0, irq_flags};
  assign mask_rd = {30'd0, irq_mask};
`else
  assign irq     = 1'b0;
  assign irq_rd  = '0;
  assign mask_rd = '0;
`endif

  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++)
      rd_word = rd_word | ch_rd[c];
    for (int k = 0; k < NUM_PARAMS; k++)
      if (avs_address == ADDR_PARAM + 6'(k))
        rd_word = params[k];
    unique case (1'b1)
      avs_address == ADDR_STATUS: rd_word = status;
      avs_address == ADDR_DIV:    rd_word = divisor;
      avs_address == ADDR_TARGET: rd_word = target;
      avs_address == ADDR_COUNT:  rd_word = count;
      avs_address == ADDR_IRQ:    rd_word = irq_rd;
      avs_address == ADDR_MASK:   rd_word = mask_rd;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      avs_readdata <= '0;
    else
      avs_readdata <= avs_read ? rd_word : 32'd0;
  end

endmodule

// File: tb/tb_acq_control_bank.sv
// Self-checking bench for acq_control_bank: register table,
// directed run-control sequences and a randomized queue model.
module tb_acq_control_bank;

  localparam int NUM_CH     = 4;
  localparam int DATA_W     = 64;
  localparam int DEPTH      = 16;
  localparam int NUM_PARAMS = 16;
  localparam int SRST_CYC   = 4;

  logic                     clk;
  logic                     reset_n;
  logic [5:0]               avs_address;
  logic                     avs_read;
  logic                     avs_write;
  logic [31:0]              avs_writedata;
  logic [31:0]              avs_readdata;
  logic                     enable;
  logic                     soft_reset_out;
  logic                     calc_done;
  logic [31:0]              divisor;
  logic [NUM_PARAMS*32-1:0] param_out;
  logic [NUM_CH*DATA_W-1:0] result_data;
  logic [NUM_CH-1:0]        result_valid;
  logic                     irq;

  acq_control_bank #(
    .NUM_CH     (NUM_CH),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .NUM_PARAMS (NUM_PARAMS),
    .SRST_CYC   (SRST_CYC)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avs_address    (avs_address),
    .avs_read       (avs_read),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .enable         (enable),
    .soft_reset_out (soft_reset_out),
    .calc_done      (calc_done),
    .divisor        (divisor),
    .param_out      (param_out),
    .result_data    (result_data),
    .result_valid   (result_valid),
    .irq            (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          do_wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  // reference model for the randomized phase
  logic [63:0] q [NUM_CH][$];
  bit          ovf_m [NUM_CH];
  logic [31:0] shadow_m [NUM_CH];
  int unsigned count_m;

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, got, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_write = 1'b1;
    avs_address = a;
    avs_writedata = d;
    @(posedge clk);
    #1;
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_read = 1'b1;
    avs_address = a;
    @(posedge clk);
    #1;
    d = avs_readdata;
    avs_read = 1'b0;
  endtask

  task automatic cyc(input logic [NUM_CH-1:0] v,
                     input logic [NUM_CH*DATA_W-1:0] d,
                     input logic cd);
    @(negedge clk);
    result_valid = v;
    result_data = d;
    calc_done = cd;
    @(posedge clk);
    #1;
    result_valid = '0;
    calc_done = 1'b0;
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] chdata(
      input int ch, input logic [31:0] hi, input logic [31:0] lo);
    logic [NUM_CH*DATA_W-1:0] r;
    r = '0;
    r[ch*DATA_W +: DATA_W] = {hi, lo};
    return r;
  endfunction

  // counts consecutive cycles soft_reset_out stays high,
  // starting with the current (already high) cycle
  task automatic srst_len(output int n);
    n = soft_reset_out ? 1 : 0;
    for (int i = 0; i < 20 && soft_reset_out; i++) begin
      @(posedge clk);
      #1;
      if (soft_reset_out) n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rv;
    int n;
    logic [NUM_CH-1:0] v;
    logic [NUM_CH*DATA_W-1:0] d;
    bit r;
    logic [5:0] a;
    logic [31:0] exp;
    int sel, ch;
    bit popped [NUM_CH];

    reset_n = 1'b0;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    calc_done = 1'b0;
    result_data = '0;
    result_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // reset state
    check("rst_enable", enable, 0);
    check("rst_srst_out", soft_reset_out, 0);
    check("rst_irq", irq, 0);
    check("rst_div_port", divisor, 1);
    check("rst_params", param_out, 0);
    rd(6'h02, rv); check("rst_div", rv, 1);
    rd(6'h01, rv); check("rst_status", rv & 32'hFFFF, 0);
    check("rst_empty", rv[23:16], 8'h0F);
    rd(6'h08, rv); check("rst_param0", rv, 0);
    rd(6'h04, rv); check("rst_count", rv, 0);

    // start+stop together from IDLE: stop wins
    wr(6'h00, 32'h3);
    rd(6'h01, rv); check("ss_state", rv[1:0], 0);
    check("ss_enable", enable, 0);

    tbl[0]  = '{1, 6'h02, 32'h0, 32'h1};
    tbl[1]  = '{1, 6'h02, 32'h7, 32'h7};
    tbl[2]  = '{1, 6'h03, 32'h55, 32'h55};
    tbl[3]  = '{1, 6'h08, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[4]  = '{1, 6'h17, 32'h12345678, 32'h12345678};
    tbl[5]  = '{1, 6'h18, 32'hFFFFFFFF, 32'h0};
    tbl[6]  = '{1, 6'h07, 32'hAAAA, 32'h0};
    tbl[7]  = '{0, 6'h3C, 32'h0, 32'h0};
    tbl[8]  = '{0, 6'h22, 32'h0, 32'h0};
`ifdef ACQ_IRQ_EN
    tbl[9]  = '{1, 6'h06, 32'h1, 32'h1};
`else
    tbl[9]  = '{1, 6'h06, 32'h1, 32'h0};
`endif
    tbl[10] = '{1, 6'h03, 32'h0, 32'h0};
    tbl[11] = '{0, 6'h04, 32'h0, 32'h0};
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].do_wr) wr(tbl[i].addr, tbl[i].wdata);
      rd(tbl[i].addr, rv);
      check($sformatf("tbl%0d", i), rv, tbl[i].exp);
    end
    check("div_port", divisor, 7);
    check("param0_port", param_out[31:0], 32'hDEADBEEF);
    check("param15_port", param_out[15*32 +: 32], 32'h12345678);

    // sample-count termination
    wr(6'h03, 32'd10);
    wr(6'h00, 32'h1);
    check("run_enable", enable, 1);
    for (int i = 0; i < 14; i++)
      cyc(4'b0001, chdata(0, 32'h1, 32'(i)), 1'b0);
    check("tgt_enable", enable, 0);
    rd(6'h01, rv); check("tgt_state", rv[1:0], 2);
    rd(6'h04, rv); check("tgt_count", rv, 10);
    rd(6'h22, rv); check("tgt_level", rv, 10);
    for (int i = 0; i < 10; i++) begin
      rd(6'h20, rv); check($sformatf("tgt_lo%0d", i), rv, i);
      rd(6'h21, rv); check($sformatf("tgt_hi%0d", i), rv, 1);
    end
    rd(6'h22, rv); check("tgt_level0", rv, 0);
    rd(6'h20, rv); check("empty_lo", rv, 0);
    rd(6'h21, rv); check("empty_hi", rv, 0);

    // calc_done with a sample in the same cycle
    wr(6'h03, 32'd0);
    wr(6'h00, 32'h1);
    cyc(4'b0001, chdata(0, 32'h0, 32'hA0), 1'b0);
    cyc(4'b0001, chdata(0, 32'h0, 32'hA1), 1'b0);
    cyc(4'b0001, chdata(0, 32'h0, 32'hA2), 1'b1);
    check("cd_enable", enable, 0);
    cyc(4'b0001, chdata(0, 32'h0, 32'hA3), 1'b0);
    rd(6'h01, rv); check("cd_state", rv[1:0], 2);
    rd(6'h22, rv); check("cd_level", rv, 3);
    for (int i = 0; i < 3; i++) begin
      rd(6'h20, rv); check($sformatf("cd_lo%0d", i), rv, 32'hA0 + i);
    end

    // overflow on ch1
    wr(6'h00, 32'h1);
    for (int i = 0; i < DEPTH + 2; i++)
      cyc(4'b0010, chdata(1, 32'hB, 32'(i)), 1'b0);
    rd(6'h26, rv); check("ovf_level", rv, DEPTH);
    rd(6'h01, rv); check("ovf_bit", rv[9], 1);
    check("ovf_any", rv[2], 1);
    for (int i = 0; i < 4; i++) begin
      rd(6'h24, rv); check($sformatf("ovf_lo%0d", i), rv, i);
      rd(6'h25, rv); check($sformatf("ovf_hi%0d", i), rv, 32'hB);
    end
    wr(6'h00, 32'h1);
    rd(6'h01, rv); check("ovf_clr", rv[9], 0);
    check("ovf_clr_any", rv[2], 0);
    check("ovf_run", rv[1:0], 1);
    rd(6'h26, rv); check("ovf_kept", rv, DEPTH - 4);

    // soft reset from RUN with data queued
    wr(6'h00, 32'h5);
    srst_len(n); check("srst_len", n, SRST_CYC);
    rd(6'h01, rv); check("srst_state", rv[1:0], 0);
    check("srst_empty", rv[23:16], 8'h0F);
    check("srst_ovf", rv[15:2], 0);
    check("srst_enable", enable, 0);
    rd(6'h08, rv); check("srst_param", rv, 32'hDEADBEEF);
    check("srst_div", divisor, 7);
    wr(6'h00, 32'h4);
    cyc('0, '0, 1'b0);
    wr(6'h00, 32'h4);
    srst_len(n); check("srst_retrig", n, SRST_CYC);

    // target of 2 and interrupt
    wr(6'h03, 32'd2);
`ifdef ACQ_IRQ_EN
    wr(6'h05, 32'h3);
    wr(6'h06, 32'h1);
`endif
    wr(6'h00, 32'h1);
    for (int i = 0; i < 3; i++)
      cyc(4'b0001, chdata(0, 32'h0, 32'(i)), 1'b0);
    rd(6'h01, rv); check("t2_state", rv[1:0], 2);
    rd(6'h04, rv); check("t2_count", rv, 2);
    rd(6'h22, rv); check("t2_level", rv, 2);
`ifdef ACQ_IRQ_EN
    check("irq_set", irq, 1);
    rd(6'h05, rv); check("irq_reg", rv[0], 1);
    wr(6'h05, 32'h1);
    check("irq_clr", irq, 0);
`else
    check("irq_off", irq, 0);
    rd(6'h05, rv); check("irq_rd0", rv, 0);
    rd(6'h06, rv); check("mask_rd0", rv, 0);
`endif

    // randomized run against the queue model
    wr(6'h03, 32'd0);
    wr(6'h00, 32'h4);
    repeat (SRST_CYC + 1) cyc('0, '0, 1'b0);
    wr(6'h00, 32'h1);
    for (int c = 0; c < NUM_CH; c++) begin
      q[c].delete();
      ovf_m[c] = 0;
      shadow_m[c] = '0;
    end
    count_m = 0;
    for (int t = 0; t < 600; t++) begin
      v = NUM_CH'($urandom & $urandom);
      for (int c = 0; c < NUM_CH; c++)
        d[c*DATA_W +: DATA_W] = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      ch = $urandom_range(0, NUM_CH - 1);
      r = (sel != 9);
      a = 6'h20 + 6'(4 * ch);
      if (sel == 5) a = a + 6'd1;
      if (sel == 6) a = a + 6'd2;
      if (sel == 7) a = 6'h01;
      if (sel == 8) a = 6'h04;
      exp = '0;
      for (int c = 0; c < NUM_CH; c++) popped[c] = 0;
      if (r) begin
        if (sel <= 4) begin
          if (q[ch].size() > 0) begin
            exp = q[ch][0][31:0];
            shadow_m[ch] = q[ch][0][63:32];
            popped[ch] = 1;
          end else begin
            shadow_m[ch] = '0;
          end
        end else if (sel == 5) begin
          exp = shadow_m[ch];
        end else if (sel == 6) begin
          exp = q[ch].size();
        end else if (sel == 7) begin
          exp = 32'd1;
          for (int c = 0; c < NUM_CH; c++) begin
            if (q[c].size() == 0) exp[16 + c] = 1'b1;
            if (ovf_m[c]) begin
              exp[8 + c] = 1'b1;
              exp[2] = 1'b1;
            end
          end
        end else begin
          exp = count_m;
        end
      end
      @(negedge clk);
      result_valid = v;
      result_data = d;
      avs_read = r;
      avs_address = a;
      for (int c = 0; c < NUM_CH; c++) begin
        if (popped[c]) void'(q[c].pop_front());
        if (v[c]) begin
          if (q[c].size() < DEPTH) begin
            q[c].push_back(d[c*DATA_W +: DATA_W]);
            if (c == 0) count_m++;
          end else begin
            ovf_m[c] = 1;
          end
        end
      end
      @(posedge clk);
      #1;
      result_valid = '0;
      avs_read = 1'b0;
      if (r) check($sformatf("rnd%0d_a%0h", t, a), avs_readdata, exp);
    end
    rd(6'h04, rv); check("rnd_count", rv, count_m);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
